// File: rtl/rom_byte_fetcher_pkg.sv
// Shared definitions for the ROM byte fetcher: FSM state encoding, byte
// width and the word-geometry derivation helpers.
package rom_byte_fetcher_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT      = 3'd1,
    CAPT      = 3'd2,
    RESP      = 3'd3,
    PREF_WAIT = 3'd4,
    PREF_CAPT = 3'd5
  } state_t;

  // Bytes held in one ROM word.
  function automatic int word_bytes(input int wordsize);
    return wordsize / BYTE_W;
  endfunction

  // Width of the byte offset inside one ROM word.
  function automatic int off_w(input int wordsize);
    return $clog2(word_bytes(wordsize));
  endfunction

endpackage

// File: rtl/rom_byte_fetcher_lane.sv
// byte_lane_select: picks one little-endian byte lane out of a ROM word
// (offset 0 selects bits [7:0]). Purely combinational.
module byte_lane_select
  import rom_byte_fetcher_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic [WORDSIZE-1:0]         word,
  input  logic [off_w(WORDSIZE)-1:0]  off,
  output logic [BYTE_W-1:0]           lane
);

  localparam int WORD_BYTES = word_bytes(WORDSIZE);
  localparam int OFF_W      = off_w(WORDSIZE);

  // Lane multiplexer over all bytes of the word.
  always_comb begin
    // NOTE: default assignment first so every path drives lane (no latch).
    lane = word[BYTE_W-1:0];
    for (int i = 1; i < WORD_BYTES; i++) begin
      if (off == OFF_W'(i)) lane = word[i*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/rom_byte_fetcher.sv
// rom_byte_fetcher: serves byte-addressed fetches from a word-addressed,
// 1-cycle-latency ROM through a one-word line buffer.
// Optional feature: define ROM_FETCH_PREFETCH_EN to add a second word buffer
// that is filled speculatively with word index+1 after each demand miss.
module rom_byte_fetcher
  import rom_byte_fetcher_pkg::*;
#(
  parameter int WORDSIZE = 32,
  parameter int ADDR_W   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  input  logic [ADDR_W-1:0]              req_addr,
  output logic                           req_ready,
  output logic                           resp_valid,
  output logic [BYTE_W-1:0]              resp_byte,
  output logic                           mem_enable,
  output logic [ADDR_W-off_w(WORDSIZE)-1:0] mem_addr,
  input  logic [WORDSIZE-1:0]            mem_data
);

  localparam int OFF_W = off_w(WORDSIZE);
  localparam int IDX_W = ADDR_W - OFF_W;

  state_t              state, next_state;
  logic                buf_valid;
  logic [WORDSIZE-1:0] buf_word;
  logic [IDX_W-1:0]    buf_tag;
  logic [OFF_W-1:0]    off_q;

  logic [IDX_W-1:0]    req_idx;
  logic [OFF_W-1:0]    req_off;
  logic                hit;
  logic [WORDSIZE-1:0] hit_word;
  logic [BYTE_W-1:0]   hit_lane;
  logic [BYTE_W-1:0]   mem_lane;
  logic                serve_hit;
  logic                issue_miss;

  assign req_idx = req_addr[ADDR_W-1:OFF_W];
  assign req_off = req_addr[OFF_W-1:0];

`ifdef ROM_FETCH_PREFETCH_EN
  logic                pbuf_valid;
  logic [WORDSIZE-1:0] pbuf_word;
  logic [IDX_W-1:0]    pbuf_tag;
  logic                pf_pending;
  logic                start_pref;
  logic                hit_a;

  assign hit_a    = buf_valid && (buf_tag == req_idx);
  assign hit      = hit_a || (pbuf_valid && (pbuf_tag == req_idx));
  assign hit_word = hit_a ? buf_word : pbuf_word;
`else
  assign hit      = buf_valid && (buf_tag == req_idx);
  assign hit_word = buf_word;
`endif

  byte_lane_select #(.WORDSIZE(WORDSIZE)) u_hit_sel (
    .word (hit_word),
    .off  (req_off),
    .lane (hit_lane)
  );

  byte_lane_select #(.WORDSIZE(WORDSIZE)) u_mem_sel (
    .word (mem_data),
    .off  (off_q),
    .lane (mem_lane)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and per-cycle control decisions.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    serve_hit  = 1'b0;
    issue_miss = 1'b0;
`ifdef ROM_FETCH_PREFETCH_EN
    start_pref = 1'b0;
`endif
    case (state)
      IDLE, RESP: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (hit) begin
            serve_hit  = 1'b1;
            next_state = RESP;
          end else begin
            issue_miss = 1'b1;
            next_state = WAIT;
          end
        end else if (state == RESP) begin
          next_state = IDLE;
`ifdef ROM_FETCH_PREFETCH_EN
          if (pf_pending) begin
            start_pref = 1'b1;
            next_state = PREF_WAIT;
          end
`endif
        end
      end
      WAIT:      next_state = CAPT;
      CAPT:      next_state = RESP;
      PREF_WAIT: next_state = PREF_CAPT;
      PREF_CAPT: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Datapath: response register, ROM interface and line buffer(s).
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_byte  <= '0;
      mem_enable <= 1'b0;
      mem_addr   <= '0;
      buf_valid  <= 1'b0;
      // NOTE: the buffer word is reset too so a hit can never expose X data.
      buf_word   <= '0;
      buf_tag    <= '0;
      off_q      <= '0;
`ifdef ROM_FETCH_PREFETCH_EN
      pbuf_valid <= 1'b0;
      pbuf_word  <= '0;
      pbuf_tag   <= '0;
      pf_pending <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      if (serve_hit) begin
        resp_valid <= 1'b1;
        resp_byte  <= hit_lane;
      end
      if (issue_miss) begin
        off_q      <= req_off;
        mem_addr   <= req_idx;
        mem_enable <= 1'b1;
      end
      if (state == CAPT) begin
        buf_word   <= mem_data;
        buf_valid  <= 1'b1;
        buf_tag    <= mem_addr;
        resp_byte  <= mem_lane;
        resp_valid <= 1'b1;
        mem_enable <= 1'b0;
      end
`ifdef ROM_FETCH_PREFETCH_EN
      // Only a completed demand miss arms the speculative next-word read.
      if (state == CAPT)      pf_pending <= 1'b1;
      else if (state == RESP) pf_pending <= 1'b0;
      if (start_pref) begin
        mem_addr   <= buf_tag + IDX_W'(1);
        mem_enable <= 1'b1;
      end
      if (state == PREF_CAPT) begin
        pbuf_word  <= mem_data;
        pbuf_valid <= 1'b1;
        pbuf_tag   <= mem_addr;
        mem_enable <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rom_byte_fetcher.sv
// Self-checking bench for rom_byte_fetcher: a registered ROM model, a
// scoreboard of expected bytes/latencies, a vector table and corner sequences.
module tb_rom_byte_fetcher;

`ifdef ROM_FETCH_PREFETCH_EN
  localparam int PF = 1;
`else
  localparam int PF = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [7:0]  resp_byte;
  logic        mem_enable;
  logic [29:0] mem_addr;
  logic [31:0] mem_data;

  rom_byte_fetcher #(.WORDSIZE(32), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_byte  (resp_byte),
    .mem_enable (mem_enable),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // ROM model: registered output, 1-cycle latency, zero when disabled.
  logic [31:0] rom [0:63];
  logic [31:0] rom_q;
  always @(posedge clk)
    rom_q <= (mem_enable && mem_addr < 30'd64) ? rom[mem_addr[5:0]] : 32'h0;
  assign mem_data = rom_q;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_enable) en_cnt <= en_cnt + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  b;
    int          acc;
    int          lat;
    logic [31:0] addr;
  } exp_t;
  exp_t sb[$];

  // Response monitor: every resp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_resp_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("resp_byte@%0h", e.addr), resp_byte, e.b);
        check($sformatf("latency@%0h", e.addr), 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [7:0] b, input int lat);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) check($sformatf("req_ready_timeout@%0h", addr), 64'd0, 64'd1);
    sb.push_back('{b, cyc, lat, addr});
  endtask

  task automatic release_req();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  b;
    int          lat;
    bit          last;
    int          en;
  } vec_t;
  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int g_en;

    vecs[0]  = '{32'h0000_0000, 8'h41, 3, 1'b0, 0};
    vecs[1]  = '{32'h0000_0001, 8'h53, 1, 1'b0, 0};
    vecs[2]  = '{32'h0000_0002, 8'h52, 1, 1'b0, 0};
    vecs[3]  = '{32'h0000_0003, 8'h4D, 1, 1'b1, 2};
    vecs[4]  = '{32'h0000_0004, 8'h28, 3, 1'b0, 0};
    vecs[5]  = '{32'h0000_0005, 8'h1C, 1, 1'b0, 0};
    vecs[6]  = '{32'h0000_0007, 8'h9C, 1, 1'b1, 2};
    vecs[7]  = '{32'h0000_004F, 8'hAB, 3, 1'b0, 0};
    vecs[8]  = '{32'h0000_004C, 8'h00, 1, 1'b0, 0};
    vecs[9]  = '{32'h0000_004D, 8'hEF, 1, 1'b0, 0};
    vecs[10] = '{32'h0000_004E, 8'hCD, 1, 1'b1, 2};
    vecs[11] = '{32'h0000_1000, 8'h00, 3, 1'b0, 0};
    vecs[12] = '{32'hFFFF_FFFD, 8'h00, 3, 1'b1, 4 + 2*PF};

    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    rom[0]     = 32'h4D52_5341;
    rom[1]     = 32'h9C0D_1C28;
    rom[2]     = 32'h1122_3344;
    rom[8]     = 32'h5566_7788;
    rom[6'h13] = 32'hABCD_EF00;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_resp_valid", resp_valid, 1'b0);
    check("reset_resp_byte",  resp_byte,  8'h00);
    check("reset_mem_enable", mem_enable, 1'b0);
    check("reset_mem_addr",   mem_addr,   30'h0);
    check("reset_req_ready",  req_ready,  1'b1);

    // Table: cold fetch, sequential hits, word crossing, far jump, out-of-ROM.
    g_en = en_cnt;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].addr, vecs[i].b, vecs[i].lat);
      if (vecs[i].last) begin
        release_req();
        drain();
        check($sformatf("mem_enable_cycles_row%0d", i), 64'(en_cnt - g_en), 64'(vecs[i].en));
        g_en = en_cnt;
      end
    end

    // req_addr changes while req_ready is low are ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0008;
    #1;
    check("ready_word2", req_ready, 1'b1);
    sb.push_back('{8'h44, cyc, 3, 32'h8});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = 32'h0000_004F;
    check("mem_addr_wait", mem_addr, 30'h2);
    @(negedge clk);
    req_addr  = 32'h0000_0021;
    check("mem_addr_capt", mem_addr, 30'h2);
    drain();

    // Reset during WAIT abandons the read and invalidates the buffer.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0020;
    #1;
    check("ready_before_abort", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("mem_enable_in_wait", mem_enable, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mem_enable_after_reset", mem_enable, 1'b0);
    check("ready_after_reset", req_ready, 1'b1);
    repeat (5) @(negedge clk);
    g_en = en_cnt;
    issue(32'h0, 8'h41, 3);
    release_req();
    drain();
    check("mem_enable_refetch", 64'(en_cnt - g_en), 64'(2 + 2*PF));

    // Miss on byte 3, three idle cycles, then byte 4 (prefetched if enabled).
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    g_en = en_cnt;
    issue(32'h3, 8'h4D, 3);
    release_req();
    while (sb.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    check("mem_enable_byte3", 64'(en_cnt - g_en), 64'(2 + 2*PF));
    g_en = en_cnt;
    issue(32'h4, 8'h28, (PF != 0) ? 1 : 3);
    release_req();
    drain();
    check("mem_enable_byte4", 64'(en_cnt - g_en), 64'(2 - 2*PF + 2*PF*0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
